// File: rtl/midi_writer.sv
// UART MIDI transmitter: takes one channel message per valid/ready handshake and
// serializes it as 8N1 bytes, optionally dropping a repeated status byte.
module midi_writer #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status,
  input  logic [3:0] channel,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       error_out
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [1:0]         last_byte_q, last_byte_d;
  logic [7:0]         last_status_q, last_status_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               load;
  logic [7:0]         msg_q [3];
  logic [7:0]         tx_byte;

  logic       bit_end;
  logic       status_ok;
  logic       two_byte;
  logic [7:0] status_byte;
  logic       skip_status;

  assign bit_end     = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
  assign status_byte = {status, channel};
  assign status_ok   = status[3] && (status != 4'hF);
  assign two_byte    = (status == 4'hC) || (status == 4'hD);
  assign skip_status = (RUNNING_STATUS != 0) && (status_byte == last_status_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    last_byte_d   = last_byte_q;
    last_status_d = last_status_q;
    err_d         = 1'b0;
    load          = 1'b0;

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (status_ok) begin
            load        = 1'b1;
            state_d     = START;
            cnt_d       = '0;
            byte_d      = skip_status ? 2'd1 : 2'd0;
            last_byte_d = two_byte ? 2'd1 : 2'd2;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q == 2'd0) last_status_d = msg_q[0];
          if (byte_q == last_byte_q) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the output itself is registered.
  always_comb begin
    case (byte_d)
      2'd0:    tx_byte = msg_q[0];
      2'd1:    tx_byte = msg_q[1];
      default: tx_byte = msg_q[2];
    endcase
    tx_d   = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = tx_byte[bit_d];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      last_byte_q   <= '0;
      last_status_q <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      last_byte_q   <= last_byte_d;
      last_status_q <= last_status_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  // NOTE: message storage has no reset; it is only read after a load overwrites it.
  always_ff @(posedge clk_in) begin
    if (load) begin
      msg_q[0] <= status_byte;
      msg_q[1] <= data_byte1 & 8'h7F;
      msg_q[2] <= data_byte2 & 8'h7F;
    end
  end

  assign ready_out   = (state_q == IDLE);
  assign tx_wire_out = tx_q;
  assign busy_out    = busy_q;
  assign error_out   = err_q;

endmodule

// File: tb/tb_midi_writer.sv
// Bench for midi_writer: cycle-exact line checks against a byte-level message model,
// on a running-status instance, a no-running-status instance and a default-baud instance.
module tb_midi_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] st, ch;
  logic [7:0] d1, d2;
  logic [2:0] valid, rst;
  wire  [2:0] ready, tx, busy, err;

  midi_writer #(.CLK_FREQ(100), .BAUD(10), .RUNNING_STATUS(1)) dut (
    .clk_in(clk), .rst_in(rst[0]), .status(st), .channel(ch), .data_byte1(d1),
    .data_byte2(d2), .valid_in(valid[0]), .ready_out(ready[0]), .tx_wire_out(tx[0]),
    .busy_out(busy[0]), .error_out(err[0]));

  midi_writer #(.CLK_FREQ(100), .BAUD(10), .RUNNING_STATUS(0)) dut_nrs (
    .clk_in(clk), .rst_in(rst[1]), .status(st), .channel(ch), .data_byte1(d1),
    .data_byte2(d2), .valid_in(valid[1]), .ready_out(ready[1]), .tx_wire_out(tx[1]),
    .busy_out(busy[1]), .error_out(err[1]));

  midi_writer dut_def (
    .clk_in(clk), .rst_in(rst[2]), .status(st), .channel(ch), .data_byte1(d1),
    .data_byte2(d2), .valid_in(valid[2]), .ready_out(ready[2]), .tx_wire_out(tx[2]),
    .busy_out(busy[2]), .error_out(err[2]));

  int         n_pass   = 0;
  int         n_checks = 0;
  logic [7:0] m_last [3];
  logic [7:0] exp_q [$];

  // Reference: the list of bytes a message should put on the line.
  function automatic bit model_msg(input int inst, input logic [3:0] s, input logic [3:0] c,
                                   input logic [7:0] a, input logic [7:0] b2);
    logic [7:0] sb;
    sb = {s, c};
    exp_q.delete();
    if (s < 4'h8 || s == 4'hF) return 1'b0;
    if (inst == 1 || sb != m_last[inst]) begin
      exp_q.push_back(sb);
      m_last[inst] = sb;
    end
    exp_q.push_back(a & 8'h7F);
    if (s != 4'hC && s != 4'hD) exp_q.push_back(b2 & 8'h7F);
    return 1'b1;
  endfunction

  // Called at a negedge with the instance idle; returns at a negedge with it idle again.
  task automatic send_msg(input int inst, input logic [3:0] s, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b2, input bit hold,
                          input string tag);
    bit   ok;
    int   bad;
    logic e;
    st = s; ch = c; d1 = a; d2 = b2;
    valid[inst] = 1'b1;
    ok = model_msg(inst, s, c, a, b2);
    n_checks++;
    if (ready[inst] !== 1'b1) $display("FAIL %s ready_before got %b want 1", tag, ready[inst]);
    else n_pass++;
    @(posedge clk); #1;
    if (!ok || !hold) valid[inst] = 1'b0;
    if (!ok) begin
      @(negedge clk);
      n_checks++;
      if ({err[inst], tx[inst], ready[inst]} !== 3'b111)
        $display("FAIL %s invalid_pulse err/tx/ready got %b want 111", tag,
                 {err[inst], tx[inst], ready[inst]});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({err[inst], tx[inst], ready[inst]} !== 3'b011)
        $display("FAIL %s invalid_after err/tx/ready got %b want 011", tag,
                 {err[inst], tx[inst], ready[inst]});
      else n_pass++;
      return;
    end
    foreach (exp_q[k]) begin
      for (int j = 0; j < 10; j++) begin
        e   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_q[k][j-1];
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (tx[inst] !== e || busy[inst] !== 1'b1 || ready[inst] !== 1'b0 || err[inst] !== 1'b0)
            bad++;
        end
        n_checks++;
        if (bad !== 0)
          $display("FAIL %s frame byte%0d=%h bit%0d bad_cycles got %0d want 0 (last tx=%b want %b)",
                   tag, k, exp_q[k], j, bad, tx[inst], e);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({ready[inst], busy[inst], tx[inst]} !== 3'b101)
      $display("FAIL %s end_of_msg ready/busy/tx got %b want 101", tag,
               {ready[inst], busy[inst], tx[inst]});
    else n_pass++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ready[i], tx[i], busy[i], err[i]} !== 4'b1100)
        $display("FAIL reset inst%0d ready/tx/busy/err got %b want 1100", i,
                 {ready[i], tx[i], busy[i], err[i]});
      else n_pass++;
    end
  endtask

  task automatic test_note_on_running_status;
    send_msg(0, 4'h9, 4'h0, 8'h3C, 8'h64, 1'b1, "note_on");
    send_msg(0, 4'h9, 4'h0, 8'h40, 8'h00, 1'b0, "running_status");
  endtask

  task automatic test_no_running_status;
    send_msg(1, 4'h9, 4'h0, 8'h3C, 8'h64, 1'b1, "nrs_first");
    send_msg(1, 4'h9, 4'h0, 8'h40, 8'h00, 1'b0, "nrs_second");
  endtask

  task automatic test_program_change;
    send_msg(0, 4'hC, 4'h5, 8'h8A, 8'($urandom), 1'b0, "program_change");
  endtask

  task automatic test_invalid;
    send_msg(0, 4'hF, 4'h3, 8'h12, 8'h34, 1'b0, "invalid_f");
    send_msg(0, 4'h8, 4'h2, 8'h45, 8'h7F, 1'b0, "after_invalid");
  endtask

  task automatic test_reset_mid_frame;
    send_msg(0, 4'hB, 4'h7, 8'h11, 8'h22, 1'b0, "rmf_pre");
    st = 4'h9; ch = 4'h7; d1 = 8'h3C; d2 = 8'h64;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (150) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx[0], ready[0], busy[0]} !== 3'b110)
      $display("FAIL reset_mid_frame tx/ready/busy got %b want 110", {tx[0], ready[0], busy[0]});
    else n_pass++;
    m_last[0] = 8'h00;
    send_msg(0, 4'h9, 4'h7, 8'h3C, 8'h64, 1'b0, "rmf_resend");
  endtask

  task automatic test_back_to_back_random;
    logic [3:0] s;
    int         r;
    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 9));
        s = (r < 7) ? 4'(8 + r) : (r == 7) ? 4'hF : 4'h2;
        send_msg(inst, s, 4'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), i < 7,
                 $sformatf("random_inst%0d_msg%0d", inst, i));
      end
    end
  endtask

  task automatic test_default_baud;
    int n_low, n_high;
    st = 4'h9; ch = 4'h1; d1 = 8'h3C; d2 = 8'h64;
    valid[2] = 1'b1;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    n_low = 0;
    while (n_low < 5000) begin
      @(negedge clk);
      if (tx[2] !== 1'b0) break;
      n_low++;
    end
    n_checks++;
    if (n_low !== 3200) $display("FAIL default_start_bit cycles got %0d want 3200", n_low);
    else n_pass++;
    n_high = 1;
    while (n_high < 5000) begin
      @(negedge clk);
      if (tx[2] !== 1'b1) break;
      n_high++;
    end
    n_checks++;
    if (n_high !== 3200) $display("FAIL default_data_bit0 cycles got %0d want 3200", n_high);
    else n_pass++;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx[2], ready[2]} !== 2'b11)
      $display("FAIL default_reset tx/ready got %b want 11", {tx[2], ready[2]});
    else n_pass++;
  endtask

  initial begin
    valid = '0;
    rst   = '1;
    st = '0; ch = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 3; i++) m_last[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    @(negedge clk);
    test_reset();
    test_note_on_running_status();
    test_no_running_status();
    test_program_change();
    test_invalid();
    test_reset_mid_frame();
    test_back_to_back_random();
    test_default_baud();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_writer.md
Name: midi_writer

Overview:
- UART MIDI transmitter; the outbound counterpart of midi_reader.
- Accepts one parsed channel message (status nibble, channel, two data bytes) via a valid/ready handshake.
- Serializes it as standard MIDI 8N1 bytes at 31250 baud on tx_wire_out, with optional running-status compression.
- Used for MIDI-thru/echo of played notes and for driving external synths from the FPGA.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- BAUD, 31250, serial bit rate. CYCLES_PER_BIT = CLK_FREQ/BAUD (integer division; 3200 at defaults).
- RUNNING_STATUS, 1, when 1 the status byte is omitted if identical to the last transmitted status byte.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- status  input  4  message type nibble (0x8..0xE valid)
- channel  input  4  MIDI channel, low nibble of the status byte
- data_byte1  input  8  first data byte; bit 7 forced to 0 on transmit
- data_byte2  input  8  second data byte; bit 7 forced to 0; ignored for 2-byte messages
- valid_in  input  1  message present
- ready_out  output  1  block can accept a message this cycle
- tx_wire_out  output  1  UART line, idle high
- busy_out  output  1  high while any byte frame is on the line
- error_out  output  1  one-cycle pulse when an invalid status nibble is accepted

Behaviour:
- Clock and reset: already decided — one clock (clk_in); reset (rst_in) is synchronous and active-high.
- Reset values:
  - tx_wire_out = 1, ready_out = 1, busy_out = 0, error_out = 0.
  - State = IDLE; last_status register cleared to 0x00 (meaning "none").
- Reset mid-frame: the line returns high on the next edge. The partial byte is abandoned and last_status is cleared.
- Handshake:
  - A transfer occurs when valid_in && ready_out on a rising edge.
  - All inputs are latched at that edge; inputs are don't-care afterwards.
  - ready_out is high only in IDLE and drops the cycle after a transfer.
- Message length by status nibble:
  - 0xC, 0xD: 2 bytes (status + data_byte1).
  - 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
- Invalid status (0x0..0x7 or 0xF):
  - Accepted, nothing transmitted, error_out pulses in the cycle after acceptance.
  - ready_out stays high; last_status is unchanged.
- Running status (RUNNING_STATUS = 1):
  - The status byte {status, channel} is skipped when it equals last_status.
  - last_status is updated when a status byte finishes transmitting.
  - With RUNNING_STATUS = 0 the status byte is always sent.
- State machine: IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE).
  - START: line 0 for CYCLES_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each exactly CYCLES_PER_BIT cycles.
  - STOP: line 1 for CYCLES_PER_BIT cycles.
  - Consecutive bytes of one message are sent back-to-back, with no extra idle between the stop bit and the next start bit.
- Latency and framing:
  - The start bit begins on the cycle after acceptance (tx_wire_out = 0 at edge N+1).
  - Each byte occupies exactly 10*CYCLES_PER_BIT cycles.
  - ready_out returns high on the cycle after the final stop bit ends, so a new message can be accepted then.
  - Minimum inter-message gap is 1 cycle.
- busy_out is high from the first start bit until the last stop bit completes.
- Counters:
  - Bit-time counter width is $clog2(CYCLES_PER_BIT); the counter wraps to 0 at CYCLES_PER_BIT-1.
  - Bit index is 3 bits; byte index is 2 bits.
- No FIFO. The upstream source holds valid_in until ready_out.

Test Plan:
All scenarios use CLK_FREQ=100, BAUD=10 (CYCLES_PER_BIT=10) unless stated.
1. Note On: status=0x9, ch=0x0, d1=0x3C, d2=0x64 -> three frames 0x90, 0x3C, 0x64; LSB first, start 0, stop 1, each bit exactly 10 cycles; ready_out high again 301 cycles after acceptance.
2. Running status: second message 0x9/ch0, d1=0x40, d2=0x00 right after scenario 1 -> only 0x40, 0x00 sent (200 cycles). Repeat with RUNNING_STATUS=0 -> 0x90 is resent (300 cycles).
3. Program Change: status=0xC, ch=0x5, d1=0x8A -> two frames 0xC5, 0x0A (bit 7 masked); data_byte2 ignored.
4. Invalid status 0xF -> error_out high for exactly 1 cycle; tx_wire_out stays 1; ready_out never drops; a following 0x8 message still sends its status byte.
5. Reset mid-frame: assert rst_in during the data bits of the second byte -> tx_wire_out=1 and ready_out=1 on the next edge; a subsequent identical message resends the status byte.
6. Held valid_in with back-to-back messages, default parameters -> bit period measured as 3200 cycles; no message dropped or duplicated; 1-cycle gap between messages.
